// File: rtl/log_mel_serializer.sv
// log_mel_serializer
//   Takes a whole 64-band log-mel frame in parallel and streams it out one
//   signed word per cycle, band 0 first. Two frame slots are used ping-pong so
//   the upstream can hand over the next frame while the current one drains.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   frame_i         : parallel frame, band b at [b*O_BW +: O_BW]
//   frame_valid_i   : frame_i holds a frame to transfer
//   frame_ready_o   : at least one slot is free (registered flags only)
//   data_o, idx_o   : current band word and its index
//   valid_o, last_o : word valid / word is band N_MEL-1
//   ready_i         : downstream accepts the word
//   frame_cnt_o     : fully drained frames, wraps at 16 bits
module log_mel_serializer #(
    parameter int O_BW  = 14,
    parameter int N_MEL = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [O_BW*N_MEL-1:0]   frame_i,
    input  logic                    frame_valid_i,
    output logic                    frame_ready_o,
    output logic [O_BW-1:0]         data_o,
    output logic [$clog2(N_MEL)-1:0] idx_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    last_o,
    output logic [15:0]             frame_cnt_o
);
    localparam int IDX_W = $clog2(N_MEL);

    logic [N_MEL-1:0][O_BW-1:0] slot [2];
    logic [1:0]       full;
    logic             wp, rp;
    logic [IDX_W-1:0] idx;
    logic [15:0]      frame_cnt;
    logic             accept, xfer;

    // Ready comes from the full flags only, so there is no combinational
    // path from frame_valid_i or ready_i back to the upstream.
    assign frame_ready_o = ~(full[0] & full[1]);
    assign valid_o       = full[rp];
    assign data_o        = slot[rp][idx];
    assign idx_o         = idx;
    assign last_o        = valid_o && (idx == IDX_W'(N_MEL - 1));
    assign frame_cnt_o   = frame_cnt;

    assign accept = frame_valid_i && frame_ready_o;
    assign xfer   = valid_o && ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0]   <= '0;
            slot[1]   <= '0;
            full      <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            // wp always points at a free slot when accept is possible, and rp
            // at a full one when draining, so the two flag updates below never
            // touch the same bit.
            if (accept) begin
                slot[wp] <= frame_i;
                full[wp] <= 1'b1;
                wp       <= ~wp;
            end
            if (xfer) begin
                if (last_o) begin
                    idx       <= '0;
                    full[rp]  <= 1'b0;
                    rp        <= ~rp;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_log_mel_serializer.sv
// Directed bench for log_mel_serializer. Inputs are driven and outputs are
// sampled on the falling edge; expected words come from the frame pattern
// codes (0: b-32, 1: 0x1555, 2: 0x2AAA, 3: b).
module tb_log_mel_serializer;
    localparam int O_BW  = 14;
    localparam int N_MEL = 64;
    typedef logic [O_BW*N_MEL-1:0] frame_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    frame_t             frame_i = '0;
    logic               frame_valid_i = 1'b0;
    logic               frame_ready_o;
    logic [O_BW-1:0]    data_o;
    logic [5:0]         idx_o;
    logic               valid_o;
    logic               ready_i = 1'b0;
    logic               last_o;
    logic [15:0]        frame_cnt_o;

    log_mel_serializer #(.O_BW(O_BW), .N_MEL(N_MEL)) dut (
        .clk(clk), .rst_n(rst_n), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o), .data_o(data_o), .idx_o(idx_o),
        .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    frame_t fr [4];
    int     md [4];

    logic [O_BW-1:0] got_d [$];
    logic [5:0]      got_i [$];
    logic            got_l [$];
    int              got_c [$];
    int              acc_c [$];
    int              stall_bad, rdy_low;
    bit              timed_out;

    function automatic logic [O_BW-1:0] ew(input int mode, input int b);
        case (mode)
            0: return O_BW'(b - 32);
            1: return 14'h1555;
            2: return 14'h2AAA;
            default: return O_BW'(b);
        endcase
    endfunction

    function automatic frame_t mk(input int mode);
        frame_t f;
        for (int b = 0; b < N_MEL; b++) f[b*O_BW +: O_BW] = ew(mode, b);
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; frame_valid_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offers nf frames from fr[] in order and collects up to max_words output
    // words; every accept cycle and every transferred word is logged.
    task automatic run(input int nf, input int max_words, input bit rnd);
        int fi = 0;
        bit acc_pend = 0, pstall = 0, done = 0;
        logic [O_BW-1:0] pd = '0;
        logic [5:0] pi = '0;
        logic pl = 0;
        got_d.delete(); got_i.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
        stall_bad = 0; rdy_low = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (acc_pend) fi++;
            if (pstall && (!valid_o || data_o !== pd || idx_o !== pi || last_o !== pl))
                stall_bad++;
            if (got_d.size() >= max_words) begin done = 1; break; end
            frame_valid_i = (fi < nf);
            if (fi < nf) begin
                frame_i = fr[fi];
                if (!frame_ready_o) rdy_low++;
            end
            acc_pend = frame_valid_i && frame_ready_o;
            if (acc_pend) acc_c.push_back(cyc);
            ready_i = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (valid_o && ready_i) begin
                got_d.push_back(data_o); got_i.push_back(idx_o);
                got_l.push_back(last_o); got_c.push_back(cyc);
            end
            pstall = valid_o && !ready_i;
            pd = data_o; pi = idx_o; pl = last_o;
        end
        timed_out = !done;
        frame_valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", last_o); end
        checks++; if (idx_o !== 6'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx_o); end
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", frame_ready_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    endtask

    task automatic test_single_frame();
        do_reset();
        fr[0] = mk(0);
        run(1, 64, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL single_timeout got %0d words exp 64", got_d.size()); end
        if (!timed_out) begin
            checks++;
            if (got_c[0] - acc_c[0] !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", got_c[0] - acc_c[0]); end
            for (int k = 0; k < 64; k++) begin
                checks++;
                if (got_d[k] !== O_BW'(k - 32) || got_i[k] !== 6'(k) || got_l[k] !== (k == 63)) begin
                    errors++;
                    $display("FAIL single_word k=%0d got d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                             k, got_d[k], got_i[k], got_l[k], O_BW'(k - 32), k, k == 63);
                end
            end
        end
        checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", frame_cnt_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", valid_o); end
    endtask

    task automatic test_back_to_back(input bit rnd);
        do_reset();
        md[0] = 1; md[1] = 2; md[2] = 3;
        for (int f = 0; f < 3; f++) fr[f] = mk(md[f]);
        run(3, 192, rnd);
        checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout rnd=%0d got %0d words exp 192", rnd, got_d.size()); end
        if (!timed_out) begin
            for (int k = 0; k < 192; k++) begin
                checks++;
                if (got_d[k] !== ew(md[k/64], k%64) || got_i[k] !== 6'(k%64) || got_l[k] !== (k%64 == 63)) begin
                    errors++;
                    $display("FAIL b2b_word rnd=%0d k=%0d got d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                             rnd, k, got_d[k], got_i[k], got_l[k], ew(md[k/64], k%64), k%64, k%64 == 63);
                end
            end
            if (!rnd) begin
                // Frame 3 may only be taken one edge after frame 1's last word
                // transfers: frames 1,2 at edges c0,c0+1, last word at c0+64.
                checks++;
                if (got_c[191] - got_c[0] !== 191) begin errors++; $display("FAIL b2b_bubbles got span %0d exp 191", got_c[191] - got_c[0]); end
                checks++;
                if (acc_c[1] - acc_c[0] !== 1) begin errors++; $display("FAIL b2b_second_accept got %0d exp 1", acc_c[1] - acc_c[0]); end
                checks++;
                if (acc_c[2] - acc_c[0] !== 65) begin errors++; $display("FAIL b2b_third_accept got %0d exp 65", acc_c[2] - acc_c[0]); end
                checks++;
                if (rdy_low !== 63) begin errors++; $display("FAIL b2b_ready_low got %0d exp 63", rdy_low); end
            end else begin
                checks++;
                if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stall_bad); end
            end
        end
        checks++; if (frame_cnt_o !== 16'd3) begin errors++; $display("FAIL b2b_cnt rnd=%0d got %0d exp 3", rnd, frame_cnt_o); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        fr[0] = mk(3); fr[1] = mk(2);
        run(2, 20, 0);
        checks++; if (idx_o !== 6'd20 || !valid_o) begin errors++; $display("FAIL midrst_pre got idx=%0d v=%b exp idx=20 v=1", idx_o, valid_o); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", valid_o); end
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", frame_ready_o); end
        checks++; if (idx_o !== 6'd0) begin errors++; $display("FAIL midrst_idx got %0d exp 0", idx_o); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", frame_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
        fr[0] = mk(1);
        run(1, 65, 0);
        checks++; if (got_d.size() !== 64) begin errors++; $display("FAIL midrst_words got %0d exp 64", got_d.size()); end
        if (got_d.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
                checks++;
                if (got_d[k] !== 14'h1555 || got_i[k] !== 6'(k)) begin
                    errors++;
                    $display("FAIL midrst_word k=%0d got d=%h i=%0d exp d=1555 i=%0d", k, got_d[k], got_i[k], k);
                end
            end
        end
        checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL midrst_after_cnt got %0d exp 1", frame_cnt_o); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        #1 release dut.frame_cnt;
        #1;
        checks++; if (frame_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %h exp ffff", frame_cnt_o); end
        fr[0] = mk(0);
        run(1, 64, 0);
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL wrap_cnt got %h exp 0", frame_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid_frame();
        test_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/log_mel_serializer.md
# log_mel_serializer

Downstream stage of the 64-band log block. Captures a full parallel frame of 64 signed log-mel words (O_BW bits each, band 0 in the LSBs) and emits them one word per cycle on a valid/ready stream, band 0 first. Two-slot ping-pong frame buffer lets the upstream deliver the next frame while the current one drains.

## Interface
- O_BW, 14: width of one signed log-mel word; matches the log stage output width.
- N_MEL, 64: bands per frame; index width is clog2(N_MEL) = 6.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- frame_i  input  O_BW*N_MEL  parallel frame; band b is frame_i[b*O_BW +: O_BW].
- frame_valid_i  input  1  frame_i holds a frame to transfer.
- frame_ready_o  output  1  at least one buffer slot is free.
- data_o  output  O_BW  signed log-mel word of the current band.
- idx_o  output  6  band index of data_o.
- valid_o  output  1  data_o/idx_o/last_o are valid.
- ready_i  input  1  downstream accepts the word.
- last_o  output  1  current word is band N_MEL-1.
- frame_cnt_o  output  16  completed (fully drained) frames, wraps 65535 -> 0.

## Operation
- State: two frame slots (O_BW*N_MEL regs each), full flags full[1:0], write pointer wp, read pointer rp, band counter idx, frame counter.
- Frame accept: frame_valid_i && frame_ready_o at a rising edge -> slot[wp] <= frame_i, full[wp] <= 1, wp toggles.
- frame_ready_o = !(full[0] && full[1]), from registered flags only; no combinational path from ready_i or frame_valid_i.
- Upstream holds frame_i stable while frame_valid_i && !frame_ready_o; block never drops or overwrites a full slot.
- Word stream: valid_o = full[rp]; data_o = slot[rp][idx*O_BW +: O_BW]; idx_o = idx; last_o = valid_o && (idx == N_MEL-1).
- Word transfer: valid_o && ready_i -> idx increments; on the last word idx <= 0, full[rp] <= 0, rp toggles, frame_cnt_o increments.
- Simultaneous accept and drain-completion in one cycle: both take effect; full flags updated per slot (different slots by construction); frame_ready_o sampled pre-edge, so with both slots full no accept occurs that cycle even though a slot frees.
- Stall: valid_o && !ready_i -> data_o, idx_o, last_o hold; the slot is never written while full.
- Sign preserved bit-exact; no arithmetic on data words.
- Reset (async, any time incl. mid-frame): full = 0, wp = rp = 0, idx = 0, frame_cnt_o = 0; buffered frames discarded. Reset outputs: valid_o 0, last_o 0, idx_o 0, frame_ready_o 1, frame_cnt_o 0, data_o 0 (slot regs clear to 0).

## Timing
- Accept at edge k -> valid_o = 1, idx_o = 0 in cycle after edge k (1-cycle latency), if the read side was idle.
- With ready_i held high: one word per cycle, N_MEL = 64 cycles per frame, back-to-back frames with no bubble when the second slot is full.
- frame_ready_o falls the cycle after the second slot fills; rises the cycle after a slot drains.
- frame_cnt_o updates at the edge that transfers the last_o word.

## Test plan
- Reset then single frame with band b = b-32 (signed), ready_i = 1 -> 64 words -32..31 in order, idx_o 0..63, last_o only at idx 63, frame_cnt_o 0 -> 1, valid_o low afterward.
- Three frames (all-0x1555, all-0x2AAA, band b = b) offered back-to-back, ready_i = 1 -> third frame waits with frame_ready_o = 0 until frame 1 drains; 192 contiguous words, no bubbles, correct order.
- ready_i pseudo-random 50% -> each word held stable across stalls; output sequence identical to ready_i = 1 case.
- Both slots full, last word of slot 0 transferring while frame_valid_i high -> no accept that edge; accept on next edge; no overwrite.
- rst_n pulsed low at idx 20 of frame 1 with frame 2 buffered -> valid_o 0, frame_ready_o 1, frame_cnt_o 0 immediately; next frame starts at idx 0.
- 65536 frames drained (fast-forwarded by forcing) -> frame_cnt_o wraps to 0.
